// File: rtl/hamming_scrub_writeback_if.sv
// rtl/hamming_scrub_writeback_if.sv - write-back request/acknowledge bus between scrubber and array
interface hamming_scrub_writeback_if #(
    parameter int ADDR_W = 8
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [11:0]       wr_data;
    logic              wr_ack;

    modport master (
        output wr_req,
        output wr_addr,
        output wr_data,
        input  wr_ack
    );

    modport slave (
        input  wr_req,
        input  wr_addr,
        input  wr_data,
        output wr_ack
    );
endinterface

// File: rtl/hamming_scrub_writeback.sv
// rtl/hamming_scrub_writeback.sv - decodes corrected Hamming words and queues scrub write-backs
// Optional error logging built only when HAMMING_SCRUB_ERR_LOG_EN is defined.
module hamming_scrub_writeback #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 8,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fix_valid,
    input  logic [11:0]             corrected_data,
    input  logic [11:0]             enc_data_old,
    input  logic [ADDR_W-1:0]       address_in,
    output logic                    data_out_valid,
    output logic [7:0]              data_out,
    output logic [ADDR_W-1:0]       data_out_addr,
    hamming_scrub_writeback_if.master wb,
    output logic                    fifo_full,
    output logic                    overflow,
    output logic [CNT_W-1:0]        err_count,
    output logic [ADDR_W-1:0]       last_err_addr
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = ADDR_W + 12;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic [0:0]         state;
    logic               wr_req_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [11:0]        wr_data_q;

    logic push;
    logic pop;
    logic accept;

    assign push      = fix_valid && (corrected_data != enc_data_old);
    assign pop       = (state == S_IDLE) && (count != '0);
    assign fifo_full = (count == FULL_COUNT);
    // A pop in the same cycle frees the slot, so a push into a full queue still lands.
    assign accept    = push && (!fifo_full || pop);

    assign wb.wr_req  = wr_req_q;
    assign wb.wr_addr = wr_addr_q;
    assign wb.wr_data = wr_data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_valid <= 1'b0;
            data_out       <= '0;
            data_out_addr  <= '0;
        end else begin
            data_out_valid <= fix_valid;
            data_out       <= fix_valid ? {corrected_data[11:8], corrected_data[6:4], corrected_data[2]} : 8'h00;
            data_out_addr  <= fix_valid ? address_in : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= {address_in, corrected_data};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !accept) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            wr_req_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        {wr_addr_q, wr_data_q} <= mem[rd_ptr];
                        wr_req_q <= 1'b1;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wb.wr_ack) begin
                        wr_req_q <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    wr_req_q <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

`ifdef HAMMING_SCRUB_ERR_LOG_EN
    logic [CNT_W-1:0]  err_count_q;
    logic [ADDR_W-1:0] last_err_addr_q;

    // Dropped pushes still count: the log tracks corrections seen, not write-backs issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count_q     <= '0;
            last_err_addr_q <= '0;
        end else if (push) begin
            if (err_count_q != '1) begin
                err_count_q <= err_count_q + 1'b1;
            end
            last_err_addr_q <= address_in;
        end
    end

    assign err_count     = err_count_q;
    assign last_err_addr = last_err_addr_q;
`else
    assign err_count     = '0;
    assign last_err_addr = '0;
`endif
endmodule
